// File: rtl/lr_stack.sv
// ============================================================================
// Module   : lr_stack
// Summary  : Link-register (return address) stack in a circular buffer, with
//            two tri-state bus ports and sticky overflow/underflow flags.
//            Optional macro LR_STACK_WRAP_EN: a push on full overwrites the oldest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lr_stack #(
  parameter int               SIZE        = 32,
  parameter int               DEPTH       = 8,
  parameter logic [SIZE-1:0]  INITIAL_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output wire  [SIZE-1:0]            a,
  output wire  [SIZE-1:0]            b,
  input  logic [SIZE-1:0]            in,
  input  logic                       oe_a,
  input  logic                       oe_b,
  input  logic                       ld,
  input  logic [SIZE-1:0]            pc,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [SIZE-1:0]            value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] c_ptr_one = PW'(1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);
  localparam logic [CW-1:0] c_cnt_full = CW'(DEPTH);

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic            r_unf;

  logic            w_we;
  logic [PW-1:0]   w_waddr;
  logic [SIZE-1:0] w_wdata;
  logic [PW-1:0]   w_top_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_ovf_set;
  logic            w_unf_set;
  logic            w_full;
  logic            w_empty;

  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);

  // Priority: push&pop (tail call), push, pop, ld. Empty push&pop is a push.
  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_top;
    w_wdata   = pc;
    w_top_nxt = r_top;
    w_cnt_nxt = r_count;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (push && pop && !w_empty) begin
      w_we = 1'b1;
    end else if (push) begin
      if (w_full) begin
        w_ovf_set = 1'b1;
`ifdef LR_STACK_WRAP_EN
        w_we      = 1'b1;
        w_waddr   = r_top + c_ptr_one;
        w_top_nxt = r_top + c_ptr_one;
`endif
      end else begin
        w_we      = 1'b1;
        w_waddr   = r_top + c_ptr_one;
        w_top_nxt = r_top + c_ptr_one;
        w_cnt_nxt = r_count + c_cnt_one;
      end
    end else if (pop) begin
      if (w_empty) begin
        w_unf_set = 1'b1;
      end else begin
        w_top_nxt = r_top - c_ptr_one;
        w_cnt_nxt = r_count - c_cnt_one;
      end
    end else if (ld) begin
      w_we    = 1'b1;
      w_wdata = in;
      if (w_empty) begin
        w_waddr   = r_top + c_ptr_one;
        w_top_nxt = r_top + c_ptr_one;
        w_cnt_nxt = c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_top   <= w_top_nxt;
      r_count <= w_cnt_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
      r_unf   <= w_unf_set | (r_unf & ~clr_err);
    end
  end

  // Entry storage is not reset; stale entries are hidden by count.
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign value = w_empty ? INITIAL_VAL : r_mem[r_top];
  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

  assign a = oe_a ? value : {SIZE{1'bz}};
  assign b = oe_b ? value : {SIZE{1'bz}};

endmodule

`default_nettype wire
